// File: rtl/univ_shift_pkg.sv
// ---------------------------------------------------------------------------
// univ_shift_pkg
//
// Shared definitions for the universal shift register slice:
//   - 3-bit operation codes decoded by univ_shift_reg
//   - burst controller FSM state encoding used by shift_burst_ctrl
// ---------------------------------------------------------------------------
package univ_shift_pkg;

  // Operation select codes. Acted upon only when en=1 and no burst runs.
  localparam logic [2:0] OP_HOLD  = 3'b000;  // q unchanged
  localparam logic [2:0] OP_LOAD  = 3'b001;  // parallel load from d
  localparam logic [2:0] OP_SHL   = 3'b010;  // logical left, si_l enters bit 0
  localparam logic [2:0] OP_SHR   = 3'b011;  // logical right, si_r enters MSB
  localparam logic [2:0] OP_ROL   = 3'b100;  // rotate left
  localparam logic [2:0] OP_ROR   = 3'b101;  // rotate right
  localparam logic [2:0] OP_ASR   = 3'b110;  // arithmetic right, MSB replicated
  localparam logic [2:0] OP_BURST = 3'b111;  // multi-cycle right shift by amt

  // Burst controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } burst_state_t;

endpackage : univ_shift_pkg

// File: rtl/shift_burst_ctrl.sv
// ---------------------------------------------------------------------------
// shift_burst_ctrl
//
// Sequencer for the multi-cycle burst right shift. Owns the IDLE/RUN FSM,
// the clamping down-counter and the busy/done handshake. While RUN it raises
// shift_r every cycle so the datapath performs one logical right shift per
// clock edge.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high; returns to IDLE, clears count/done
//   start    in   burst request (en=1 and op=BURST); honoured only in IDLE
//   amt      in   requested shift count, clamped to WIDTH
//   busy     out  burst in progress (FSM in RUN)
//   done     out  registered one-cycle pulse after the last shift
//   shift_r  out  datapath strobe: shift right on this edge
// ---------------------------------------------------------------------------
module shift_burst_ctrl
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic             shift_r
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  burst_state_t     state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             done_next;

  // Requests beyond WIDTH would only shift in more si_r bits over bits that
  // are already replaced, so the count saturates at WIDTH.
  logic [CNT_W-1:0] amt_clamped;
  assign amt_clamped = (amt > CNT_MAX) ? CNT_MAX : amt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (amt == '0) begin
            // Zero-length burst: nothing to shift, but the requester still
            // gets its completion pulse.
            done_next = 1'b1;
          end else begin
            // Start edge only arms the counter; first shift is next edge.
            cnt_next   = amt_clamped;
            state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state == ST_RUN);
  assign shift_r = (state == ST_RUN);

endmodule : shift_burst_ctrl

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// Parameterised universal shift register: hold, parallel load, logical
// shifts, rotates, arithmetic shift right and a multi-cycle burst right
// shift sequenced by shift_burst_ctrl. Single-step ops take effect on the
// next rising edge and may be issued every cycle.
//
// Parameters:
//   WIDTH   register width (>= 2)
//   CNT_W   derived burst count width, $clog2(WIDTH+1); not overridable
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high; clears q, busy, done immediately
//   en     in   operation enable; op honoured only when en=1 and busy=0
//   op     in   operation select (see univ_shift_pkg)
//   si_l   in   serial input into bit 0 for SHL
//   si_r   in   serial input into bit WIDTH-1 for SHR and burst
//   d      in   parallel load data
//   amt    in   burst shift count, sampled with op=BURST
//   q      out  register contents
//   so_l   out  q[WIDTH-1]
//   so_r   out  q[0]
//   busy   out  burst in progress
//   done   out  one-cycle pulse after burst completion
// ---------------------------------------------------------------------------
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             si_l,
  input  logic             si_r,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);

  logic             accept;     // op is acted upon this edge
  logic             start;      // burst request towards the controller
  logic             shift_r;    // controller-driven burst shift strobe
  logic [WIDTH-1:0] q_next;

  assign accept = en && !busy;
  assign start  = en && (op == OP_BURST);

  shift_burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .amt     (amt),
    .busy    (busy),
    .done    (done),
    .shift_r (shift_r)
  );

  // Burst shifting takes priority; while it runs, op/d/en are ignored
  // because accept is low whenever busy is high.
  always_comb begin
    q_next = q;
    if (shift_r) begin
      q_next = {si_r, q[WIDTH-1:1]};
    end else if (accept) begin
      case (op)
        OP_LOAD:  q_next = d;
        OP_SHL:   q_next = {q[WIDTH-2:0], si_l};
        OP_SHR:   q_next = {si_r, q[WIDTH-1:1]};
        OP_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        OP_ROR:   q_next = {q[0], q[WIDTH-1:1]};
        OP_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
        // HOLD keeps q; BURST's start edge performs no shift.
        OP_HOLD,
        OP_BURST: q_next = q;
        default:  q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  assign so_l = q[WIDTH-1];
  assign so_r = q[0];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Self-checking bench for univ_shift_reg at WIDTH=8. A table of directed
// vectors (inputs plus hand-computed post-edge outputs) covers single-step
// ops and bursts; hand-written sequences cover asynchronous reset, both
// idle and mid-burst.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       op;
  logic             si_l;
  logic             si_r;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             so_l;
  logic             so_r;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .op    (op),
    .si_l  (si_l),
    .si_r  (si_r),
    .d     (d),
    .amt   (amt),
    .q     (q),
    .so_l  (so_l),
    .so_r  (so_r),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             en;
    logic [2:0]       op;
    logic             si_l;
    logic             si_r;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] exp_q;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [WIDTH-1:0] eq,
                           input logic eb, input logic ed);
    check({name, " q"},    32'(q),    32'(eq));
    check({name, " so_l"}, 32'(so_l), 32'(eq[WIDTH-1]));
    check({name, " so_r"}, 32'(so_r), 32'(eq[0]));
    check({name, " busy"}, 32'(busy), 32'(eb));
    check({name, " done"}, 32'(done), 32'(ed));
  endtask

  task automatic add(input string name, input logic e, input logic [2:0] o,
                     input logic sl, input logic sr, input logic [7:0] dd,
                     input logic [3:0] a, input logic [7:0] eq,
                     input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.en = e; v.op = o; v.si_l = sl; v.si_r = sr;
    v.d = dd; v.amt = a; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  // Drive one operation, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic e, input logic [2:0] o, input logic sl,
                      input logic sr, input logic [7:0] dd, input logic [3:0] a);
    en = e; op = o; si_l = sl; si_r = sr; d = dd; amt = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; op = OP_HOLD; si_l = 1'b0; si_r = 1'b0; d = '0; amt = '0;

    // ---- basic ops, en=0 hold, rotates, ASR ----
    add("load_a5",    1, OP_LOAD,  0, 0, 8'hA5, 0, 8'hA5, 0, 0);
    add("shl_1",      1, OP_SHL,   1, 0, 8'h00, 0, 8'h4B, 0, 0);
    add("shr_0",      1, OP_SHR,   0, 0, 8'h00, 0, 8'h25, 0, 0);
    add("en0_a",      0, OP_LOAD,  1, 1, 8'hFF, 0, 8'h25, 0, 0);
    add("en0_b",      0, OP_SHL,   1, 1, 8'hFF, 0, 8'h25, 0, 0);
    add("en0_c",      0, OP_BURST, 1, 1, 8'hFF, 3, 8'h25, 0, 0);
    add("load_81a",   1, OP_LOAD,  0, 0, 8'h81, 0, 8'h81, 0, 0);
    add("rol",        1, OP_ROL,   0, 0, 8'h00, 0, 8'h03, 0, 0);
    add("load_81b",   1, OP_LOAD,  0, 0, 8'h81, 0, 8'h81, 0, 0);
    add("ror",        1, OP_ROR,   0, 0, 8'h00, 0, 8'hC0, 0, 0);
    add("load_80",    1, OP_LOAD,  0, 0, 8'h80, 0, 8'h80, 0, 0);
    add("asr_1",      1, OP_ASR,   0, 0, 8'h00, 0, 8'hC0, 0, 0);
    add("asr_2",      1, OP_ASR,   0, 0, 8'h00, 0, 8'hE0, 0, 0);
    add("hold",       1, OP_HOLD,  1, 1, 8'hFF, 0, 8'hE0, 0, 0);
    add("shr_1",      1, OP_SHR,   0, 1, 8'h00, 0, 8'hF0, 0, 0);
    // ---- burst of 3, ops ignored while busy, op accepted in done cycle ----
    add("load_f0",    1, OP_LOAD,  0, 0, 8'hF0, 0, 8'hF0, 0, 0);
    add("b3_start",   1, OP_BURST, 0, 0, 8'h00, 3, 8'hF0, 1, 0);
    add("b3_s1",      1, OP_LOAD,  0, 0, 8'hFF, 0, 8'h78, 1, 0);
    add("b3_s2",      1, OP_LOAD,  0, 0, 8'hFF, 0, 8'h3C, 1, 0);
    add("b3_s3",      1, OP_LOAD,  0, 0, 8'hFF, 0, 8'h1E, 0, 1);
    add("load_55",    1, OP_LOAD,  0, 0, 8'h55, 0, 8'h55, 0, 0);
    add("after_55",   1, OP_HOLD,  0, 0, 8'h00, 0, 8'h55, 0, 0);
    // ---- zero-length burst ----
    add("b0_start",   1, OP_BURST, 0, 1, 8'h00, 0, 8'h55, 0, 1);
    add("b0_after",   0, OP_HOLD,  0, 1, 8'h00, 0, 8'h55, 0, 0);
    // ---- burst with si_r=1 and a different background ----
    add("load_00",    1, OP_LOAD,  0, 0, 8'h00, 0, 8'h00, 0, 0);
    add("b2_start",   1, OP_BURST, 0, 0, 8'h00, 2, 8'h00, 1, 0);
    add("b2_s1",      0, OP_HOLD,  0, 1, 8'h00, 0, 8'h80, 1, 0);
    add("b2_s2",      0, OP_HOLD,  0, 1, 8'h00, 0, 8'hC0, 0, 1);
    // ---- amt=12 clamped to 8 ----
    add("load_ff",    1, OP_LOAD,  0, 0, 8'hFF, 0, 8'hFF, 0, 0);
    add("b12_start",  1, OP_BURST, 0, 0, 8'h00, 12, 8'hFF, 1, 0);
    add("b12_s1",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h7F, 1, 0);
    add("b12_s2",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h3F, 1, 0);
    add("b12_s3",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h1F, 1, 0);
    add("b12_s4",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h0F, 1, 0);
    add("b12_s5",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h07, 1, 0);
    add("b12_s6",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h03, 1, 0);
    add("b12_s7",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h01, 1, 0);
    add("b12_s8",     0, OP_HOLD,  0, 0, 8'h00, 0, 8'h00, 0, 1);
    add("b12_after",  0, OP_HOLD,  0, 0, 8'h00, 0, 8'h00, 0, 0);

    // ---- reset state ----
    #12;
    check_all("in_reset", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- asynchronous reset with q=A5, no clock edge in between ----
    step(1, OP_LOAD, 0, 0, 8'hA5, 0);
    check_all("pre_async", 8'hA5, 1'b0, 1'b0);
    en = 1'b0;
    #2 reset = 1'b1;
    #1 check_all("async_rst", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- table ----
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].op, vecs[i].si_l, vecs[i].si_r,
           vecs[i].d, vecs[i].amt);
      check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_busy,
                vecs[i].exp_done);
    end

    // ---- reset mid-burst aborts without done ----
    step(1, OP_LOAD, 0, 0, 8'hF0, 0);
    step(1, OP_BURST, 0, 0, 8'h00, 8);
    check_all("rb_start", 8'hF0, 1'b1, 1'b0);
    step(0, OP_HOLD, 0, 0, 8'h00, 0);
    step(0, OP_HOLD, 0, 0, 8'h00, 0);
    check_all("rb_2shift", 8'h3C, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_all("rb_async", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(0, OP_HOLD, 0, 0, 8'h00, 0);
      check($sformatf("rb_nodone_%0d", k), 32'(done), 32'd0);
      check($sformatf("rb_nobusy_%0d", k), 32'(busy), 32'd0);
    end
    step(1, OP_SHL, 1, 0, 8'h00, 0);
    check_all("rb_shl", 8'h01, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_univ_shift_reg
